// File: rtl/knn_vote.sv
// knn_vote: majority class vote over the K nearest sorted entries, one entry or
// class counter per cycle; ties go to the class whose first member is nearest.
module knn_vote #(
    parameter int N      = 64,
    parameter int W      = 32,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_sort,
    input  logic [W*N-1:0]          distance_array_sorted,
    input  logic [TYPE_W*N-1:0]     type_array_sorted,
    output logic [TYPE_W-1:0]       class_out,
    output logic [$clog2(K+1)-1:0]  class_votes,
    output logic [W-1:0]            nearest_dist,
    output logic                    class_valid,
    output logic                    busy
);
    localparam int CW = $clog2(K+1);
    localparam int NC = 2**TYPE_W;
    localparam int IW = K > 1 ? $clog2(K) : 1;
    localparam int SW = TYPE_W + 1;

    typedef enum logic [2:0] {IDLE, CAPTURE, COUNT, ARGMAX, DONE} state_t;

    state_t              state;
    logic                vs_q;
    logic [TYPE_W-1:0]   types [K];
    logic [W-1:0]        dist0;
    logic [CW-1:0]       cnt [NC];
    logic [IW-1:0]       first [NC];
    logic [IW-1:0]       idx;
    logic [SW-1:0]       scan;
    logic [CW-1:0]       rd_cnt, best_cnt;
    logic [IW-1:0]       rd_first, best_first;
    logic [TYPE_W-1:0]   rd_c, best_c;
    logic                start, take;
    logic [TYPE_W-1:0]   cur;

    assign start = valid_sort & ~vs_q;
    assign cur   = types[idx];
    // The scan is pipelined: counters read one cycle, compared against the best the next.
    assign take  = (scan != '0) && ((rd_cnt > best_cnt) ||
                   (rd_cnt == best_cnt && rd_cnt != '0 && rd_first < best_first));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            vs_q         <= 1'b0;
            dist0        <= '0;
            idx          <= '0;
            scan         <= '0;
            rd_cnt       <= '0;
            rd_first     <= '0;
            rd_c         <= '0;
            best_cnt     <= '0;
            best_first   <= '0;
            best_c       <= '0;
            class_out    <= '0;
            class_votes  <= '0;
            nearest_dist <= '0;
            class_valid  <= 1'b0;
            busy         <= 1'b0;
            for (int k = 0; k < K; k++) types[k] <= '0;
            for (int c = 0; c < NC; c++) begin
                cnt[c]   <= '0;
                first[c] <= '0;
            end
        end else begin
            vs_q <= valid_sort;
            case (state)
                IDLE: if (start) begin
                    for (int k = 0; k < K; k++)
                        types[k] <= type_array_sorted[(k+1)*TYPE_W-1 -: TYPE_W];
                    for (int c = 0; c < NC; c++) cnt[c] <= '0;
                    dist0 <= distance_array_sorted[W-1:0];
                    busy  <= 1'b1;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    idx        <= '0;
                    scan       <= '0;
                    best_cnt   <= '0;
                    best_first <= '1;
                    best_c     <= '0;
                    state      <= COUNT;
                end
                COUNT: begin
                    if (cnt[cur] == '0) first[cur] <= idx;
                    cnt[cur] <= cnt[cur] + CW'(1);
                    idx      <= idx + IW'(1);
                    if (idx == IW'(K-1)) state <= ARGMAX;
                end
                ARGMAX: begin
                    if (scan != SW'(NC)) begin
                        rd_cnt   <= cnt[scan[TYPE_W-1:0]];
                        rd_first <= first[scan[TYPE_W-1:0]];
                        rd_c     <= scan[TYPE_W-1:0];
                    end
                    if (take) begin
                        best_cnt   <= rd_cnt;
                        best_first <= rd_first;
                        best_c     <= rd_c;
                    end
                    scan <= scan + SW'(1);
                    if (scan == SW'(NC)) begin
                        class_out    <= take ? rd_c : best_c;
                        class_votes  <= take ? rd_cnt : best_cnt;
                        nearest_dist <= dist0;
                        class_valid  <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    class_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
